// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered WIDTH-bit ALU with iterative MUL, carry/zero flags and valid/ready handshakes
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  operation handshake; y, im, op and c_flag are captured on accept
//   op                   0 ADD, 1 ADC, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SHL, 7 MUL
//   y, im                operands A and B
//   out_valid/out_ready  result handshake
//   sgm, cout            result and its carry/borrow/overflow
//   c_flag, z_flag       persistent flags, updated at result handoff only
module alu_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] im,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sgm,
  output logic             cout,
  output logic             c_flag,
  output logic             z_flag
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_ADC = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_BUSY = 2'd1,
    DONE     = 2'd2
  } state_t;

  state_t state, next_state;

  logic               accept;
  logic               mul_last;
  logic [WIDTH:0]     alu_res;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] prod_next;
  logic [CW-1:0]      cnt;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready;
  assign mul_last  = (cnt == CW'(WIDTH - 1));

  // Single-cycle ops: bit WIDTH of alu_res is the carry/borrow out.
  // The (WIDTH+1)-bit subtraction leaves the borrow (y < im) in the top bit.
  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = {1'b0, y} + {1'b0, im};
      OP_ADC:  alu_res = {1'b0, y} + {1'b0, im} + {{WIDTH{1'b0}}, c_flag};
      OP_SUB:  alu_res = {1'b0, y} - {1'b0, im};
      OP_AND:  alu_res = {1'b0, y & im};
      OP_OR:   alu_res = {1'b0, y | im};
      OP_XOR:  alu_res = {1'b0, y ^ im};
      OP_SHL:  alu_res = {y, 1'b0};
      default: alu_res = '0;
    endcase
  end

  // Shift-add step: add the shifted multiplicand when the current multiplier LSB is set.
  assign prod_next = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = (op == OP_MUL) ? MUL_BUSY : DONE;
        end
      end
      MUL_BUSY: begin
        if (mul_last) begin
          next_state = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sgm    <= '0;
      cout   <= 1'b0;
      c_flag <= 1'b0;
      z_flag <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (op == OP_MUL) begin
              mcand  <= {{WIDTH{1'b0}}, y};
              mplier <= im;
              acc    <= '0;
              cnt    <= '0;
            end else begin
              sgm  <= alu_res[WIDTH-1:0];
              cout <= alu_res[WIDTH];
            end
          end
        end
        MUL_BUSY: begin
          acc    <= prod_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (mul_last) begin
            sgm  <= prod_next[WIDTH-1:0];
            cout <= |prod_next[2*WIDTH-1:WIDTH];
          end
        end
        DONE: begin
          if (out_ready) begin
            c_flag <= cout;
            z_flag <= (sgm == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
